// File: rtl/clock_sequencer.sv
// -----------------------------------------------------------------------------
// clock_sequencer
//
// Sequences one clock_generation instance. Owns the half-rate counter, decodes
// the half/quarter period strobes from registered state, and walks the
// generated clock through IDLE -> INIT -> RUN -> CLEAR so that the clock is
// always parked at its configured idle level before it goes inactive.
//
// Ports
//   clk, async_rst_n        : system clock (posedge), async active-low reset
//   clk_en                  : global enable; low freezes all state, zeroes strobes
//   start_i / stop_i        : start (sampled in IDLE) / stop (sampled in INIT, RUN)
//   half_rate_i             : system cycles per half period (latched on start)
//   idle_polarity_i         : parked clock level (latched on start)
//   pause_polarity_i        : level held during a pause (latched on start)
//   pause_req_i             : level request to pause the pausable clock
//   io_clk_i                : unpausable clock level fed back from clock_generation
//   set_clock_low_o/high_o  : one-cycle strobes in INIT forcing the idle level
//   clock_active_o          : high in RUN
//   clear_state_o           : one-cycle strobe in CLEAR
//   half_rate_elapsed_o     : strobe at counter == half_rate-1
//   quarter_rate_elapsed_o  : strobe at counter == (half_rate>>1)-1
//   pause_en_o              : registered pause enable
//   pause_polarity_o        : latched pause polarity
//   busy_o                  : high in any state other than IDLE
//   cfg_error_o             : sticky flag for a start rejected for half_rate < 2
//
// Handshake: start_i and stop_i are level samples, not valid/ready pairs. A
// start is taken on the single enabled IDLE cycle where start_i=1 and
// stop_i=0; stop_i wins whenever both are high. A stop seen in INIT or RUN is
// remembered until CLEAR.
// -----------------------------------------------------------------------------

package clks_alot_p;
  localparam int RATE_COUNTER_WIDTH = 16;
endpackage

module clock_sequencer #(
  parameter int RATE_COUNTER_WIDTH = clks_alot_p::RATE_COUNTER_WIDTH
) (
  input  logic                          clk,
  input  logic                          async_rst_n,
  input  logic                          clk_en,
  input  logic                          start_i,
  input  logic                          stop_i,
  input  logic [RATE_COUNTER_WIDTH-1:0] half_rate_i,
  input  logic                          idle_polarity_i,
  input  logic                          pause_polarity_i,
  input  logic                          pause_req_i,
  input  logic                          io_clk_i,
  output logic                          set_clock_low_o,
  output logic                          set_clock_high_o,
  output logic                          clock_active_o,
  output logic                          clear_state_o,
  output logic                          half_rate_elapsed_o,
  output logic                          quarter_rate_elapsed_o,
  output logic                          pause_en_o,
  output logic                          pause_polarity_o,
  output logic                          busy_o,
  output logic                          cfg_error_o
);

  localparam int W = RATE_COUNTER_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_RUN   = 2'd2,
    ST_CLEAR = 2'd3
  } state_t;

  state_t         r_state;
  state_t         w_next_state;
  logic [W-1:0]   r_cnt;
  logic [W-1:0]   r_half_rate;
  logic           r_idle_pol;
  logic           r_pause_pol;
  logic           r_stop_pend;
  logic           r_cfg_err;
  logic           r_pause_en;

  logic [W-1:0]   w_half_last;
  logic [W-1:0]   w_quarter_last;
  logic           w_half_hit;
  logic           w_quarter_hit;
  logic           w_start_req;
  logic           w_start_ok;
  logic           w_start_bad;
  logic           w_exit;

  // Decode points are computed from the latched rate, which is at least 2 in
  // RUN, so neither subtraction can underflow while the decodes are used.
  assign w_half_last    = r_half_rate - W'(1);
  assign w_quarter_last = (r_half_rate >> 1) - W'(1);

  assign w_half_hit    = (r_state == ST_RUN) && (r_cnt == w_half_last);
  assign w_quarter_hit = (r_state == ST_RUN) && (r_cnt == w_quarter_last);

  assign w_start_req = start_i && !stop_i;
  assign w_start_ok  = w_start_req && (half_rate_i >= W'(2));
  assign w_start_bad = w_start_req && (half_rate_i <  W'(2));

  // Leave RUN only on a half-period edge that moves the clock back onto the
  // idle level. If the clock already sits at idle, this edge would take it
  // away, so the stop waits one more half period.
  assign w_exit = w_half_hit && (r_stop_pend || stop_i) && (io_clk_i != r_idle_pol);

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    if (clk_en) begin
      case (r_state)
        ST_IDLE:  if (w_start_ok) w_next_state = ST_INIT;
        ST_INIT:  w_next_state = ST_RUN;
        ST_RUN:   if (w_exit) w_next_state = ST_CLEAR;
        ST_CLEAR: w_next_state = ST_IDLE;
        default:  w_next_state = ST_IDLE;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Datapath: counter, latched configuration, sticky flags
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_cnt       <= '0;
      r_half_rate <= '0;
      r_idle_pol  <= 1'b0;
      r_pause_pol <= 1'b0;
      r_stop_pend <= 1'b0;
      r_cfg_err   <= 1'b0;
      r_pause_en  <= 1'b0;
    end else if (clk_en) begin
      r_pause_en <= pause_req_i && (w_next_state == ST_RUN);
      case (r_state)
        ST_IDLE: begin
          if (w_start_ok) begin
            r_half_rate <= half_rate_i;
            r_idle_pol  <= idle_polarity_i;
            r_pause_pol <= pause_polarity_i;
            r_cfg_err   <= 1'b0;
          end else if (w_start_bad) begin
            r_cfg_err   <= 1'b1;
          end
        end
        ST_INIT: begin
          r_cnt <= '0;
          if (stop_i) r_stop_pend <= 1'b1;
        end
        ST_RUN: begin
          // The counter keeps running through a pause; only the pausable
          // clock is held by clock_generation.
          r_cnt <= w_half_hit ? '0 : r_cnt + W'(1);
          if (stop_i) r_stop_pend <= 1'b1;
        end
        ST_CLEAR: begin
          r_stop_pend <= 1'b0;
        end
        default: begin
          r_stop_pend <= 1'b0;
        end
      endcase
    end
  end

  // Strobes are decoded from registers and qualified by clk_en so that a
  // stalled cycle never produces an edge request.
  assign set_clock_high_o       = clk_en && (r_state == ST_INIT) &&  r_idle_pol;
  assign set_clock_low_o        = clk_en && (r_state == ST_INIT) && !r_idle_pol;
  assign clear_state_o          = clk_en && (r_state == ST_CLEAR);
  assign half_rate_elapsed_o    = clk_en && w_half_hit;
  assign quarter_rate_elapsed_o = clk_en && w_quarter_hit;

  assign clock_active_o   = (r_state == ST_RUN);
  assign busy_o           = (r_state != ST_IDLE);
  assign pause_en_o       = r_pause_en;
  assign pause_polarity_o = r_pause_pol;
  assign cfg_error_o      = r_cfg_err;

endmodule

// File: tb/tb_clock_sequencer.sv
// -----------------------------------------------------------------------------
// tb_clock_sequencer
//
// Directed scenarios for clock_sequencer. A small stand-in for clock_generation
// turns the set/half strobes into io_clk. Each driven cycle pushes the output
// vector required after the next rising edge; a monitor pops and compares it
// two time units after that edge.
//
// Output vector bit order (MSB..LSB):
//   set_low, set_high, active, clear, half, quarter, pause_en, pause_pol,
//   busy, cfg_err
// -----------------------------------------------------------------------------

module tb_clock_sequencer;

  localparam int W = 16;

  // Clock / reset
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic         clk_en;
  logic         start_i;
  logic         stop_i;
  logic [W-1:0] half_rate_i;
  logic         idle_polarity_i;
  logic         pause_polarity_i;
  logic         pause_req_i;
  logic         io_clk;
  logic         set_clock_low_o;
  logic         set_clock_high_o;
  logic         clock_active_o;
  logic         clear_state_o;
  logic         half_rate_elapsed_o;
  logic         quarter_rate_elapsed_o;
  logic         pause_en_o;
  logic         pause_polarity_o;
  logic         busy_o;
  logic         cfg_error_o;

  clock_sequencer #(.RATE_COUNTER_WIDTH(W)) dut (
    .clk                    (clk),
    .async_rst_n            (rst_n),
    .clk_en                 (clk_en),
    .start_i                (start_i),
    .stop_i                 (stop_i),
    .half_rate_i            (half_rate_i),
    .idle_polarity_i        (idle_polarity_i),
    .pause_polarity_i       (pause_polarity_i),
    .pause_req_i            (pause_req_i),
    .io_clk_i               (io_clk),
    .set_clock_low_o        (set_clock_low_o),
    .set_clock_high_o       (set_clock_high_o),
    .clock_active_o         (clock_active_o),
    .clear_state_o          (clear_state_o),
    .half_rate_elapsed_o    (half_rate_elapsed_o),
    .quarter_rate_elapsed_o (quarter_rate_elapsed_o),
    .pause_en_o             (pause_en_o),
    .pause_polarity_o       (pause_polarity_o),
    .busy_o                 (busy_o),
    .cfg_error_o            (cfg_error_o)
  );

  // Stand-in for clock_generation: park on set strobes, toggle on half period.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   io_clk <= 1'b0;
    else if (set_clock_low_o)     io_clk <= 1'b0;
    else if (set_clock_high_o)    io_clk <= 1'b1;
    else if (half_rate_elapsed_o) io_clk <= ~io_clk;
  end

  logic [9:0] outs;
  assign outs = {set_clock_low_o, set_clock_high_o, clock_active_o, clear_state_o,
                 half_rate_elapsed_o, quarter_rate_elapsed_o, pause_en_o,
                 pause_polarity_o, busy_o, cfg_error_o};

  // Scoreboard
  logic [9:0] exp_q[$];
  string      tag_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check_val(input string tag, input logic [9:0] got, input logic [9:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] ov(input bit sl, input bit sh, input bit act,
                                    input bit clr, input bit hf, input bit qt,
                                    input bit pe, input bit pp, input bit bsy,
                                    input bit err);
    return {sl, sh, act, clr, hf, qt, pe, pp, bsy, err};
  endfunction

  // Monitor: compare two time units after each rising edge
  logic [9:0] mon_exp;
  string      mon_tag;
  always @(posedge clk) begin
    #2;
    if (exp_q.size() > 0) begin
      mon_exp = exp_q.pop_front();
      mon_tag = tag_q.pop_front();
      check_val(mon_tag, outs, mon_exp);
    end
  end

  // Driver: one cycle of stimulus plus the outputs required after its edge
  task automatic cyc(input string tag, input bit st, input bit sp, input bit pr,
                     input bit en, input logic [9:0] exp);
    @(negedge clk);
    start_i     = st;
    stop_i      = sp;
    pause_req_i = pr;
    clk_en      = en;
    exp_q.push_back(exp);
    tag_q.push_back(tag);
  endtask

  task automatic drain();
    @(posedge clk);
    #4;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clk_en = 1'b1; start_i = 1'b0; stop_i = 1'b0; pause_req_i = 1'b0;
    half_rate_i = '0; idle_polarity_i = 1'b0; pause_polarity_i = 1'b0;
    #3;
    check_val("reset_outs", outs, 10'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Basic start, half_rate 4, idle low; stop while clock is at idle level
    half_rate_i = W'(4); idle_polarity_i = 1'b0; pause_polarity_i = 1'b1;
    cyc("s1_init", 1, 0, 0, 1, ov(1,0,0,0,0,0,0,1,1,0));
    for (int k = 0; k < 16; k++)
      cyc("s1_run", 0, (k == 12), 0, 1, ov(0,0,1,0, (k%4 == 3), (k%4 == 1), 0,1,1,0));
    cyc("s1_clear", 0, 0, 0, 1, ov(0,0,0,1,0,0,0,1,1,0));
    cyc("s1_idle",  0, 0, 0, 1, ov(0,0,0,0,0,0,0,1,0,0));

    // half_rate 3, idle high; stop raised while io_clk is already high
    half_rate_i = W'(3); idle_polarity_i = 1'b1; pause_polarity_i = 1'b0;
    cyc("s2_init", 1, 0, 0, 1, ov(0,1,0,0,0,0,0,0,1,0));
    for (int k = 0; k < 12; k++)
      cyc("s2_run", 0, (k == 7), 0, 1, ov(0,0,1,0, (k%3 == 2), (k%3 == 0), 0,0,1,0));
    cyc("s2_clear", 0, 0, 0, 1, ov(0,0,0,1,0,0,0,0,1,0));
    cyc("s2_idle",  0, 0, 0, 1, ov(0,0,0,0,0,0,0,0,0,0));

    // Rejected configuration, then a minimal valid start
    half_rate_i = W'(1);
    cyc("s3_reject", 1, 0, 0, 1, ov(0,0,0,0,0,0,0,0,0,1));
    cyc("s3_hold",   0, 0, 0, 1, ov(0,0,0,0,0,0,0,0,0,1));
    half_rate_i = W'(2); idle_polarity_i = 1'b0; pause_polarity_i = 1'b1;
    cyc("s3_start",  1, 0, 0, 1, ov(1,0,0,0,0,0,0,1,1,0));

    // Clock enable stall mid-RUN
    for (int k = 0; k < 5; k++)
      cyc("s4_pre", 0, 0, 0, 1, ov(0,0,1,0, (k%2 == 1), (k%2 == 0), 0,1,1,0));
    for (int s = 0; s < 5; s++)
      cyc("s4_stall", 0, 0, 0, 0, ov(0,0,1,0,0,0,0,1,1,0));
    for (int k = 5; k < 9; k++)
      cyc("s4_post", 0, 0, 0, 1, ov(0,0,1,0, (k%2 == 1), (k%2 == 0), 0,1,1,0));
    drain();

    // Asynchronous reset mid-RUN
    rst_n = 1'b0;
    #1;
    check_val("s6_async_reset", outs, 10'b0);
    @(negedge clk);
    rst_n = 1'b1;
    half_rate_i = W'(4);
    cyc("s6_start_stop", 1, 1, 0, 1, ov(0,0,0,0,0,0,0,0,0,0));
    cyc("s6_idle",       0, 0, 0, 1, ov(0,0,0,0,0,0,0,0,0,0));

    // Pause held through a stop, half_rate 4, idle high
    half_rate_i = W'(4); idle_polarity_i = 1'b1; pause_polarity_i = 1'b1;
    cyc("s5_init", 1, 0, 0, 1, ov(0,1,0,0,0,0,0,1,1,0));
    for (int k = 0; k < 8; k++)
      cyc("s5_run", 0, (k == 5), (k >= 1), 1,
          ov(0,0,1,0, (k%4 == 3), (k%4 == 1), (k >= 1), 1,1,0));
    cyc("s5_clear", 0, 0, 1, 1, ov(0,0,0,1,0,0,0,1,1,0));
    cyc("s5_idle",  0, 0, 1, 1, ov(0,0,0,0,0,0,0,1,0,0));
    cyc("s5_rest",  0, 0, 0, 1, ov(0,0,0,0,0,0,0,1,0,0));
    drain();

    check_val("queue_empty", 10'(exp_q.size()), 10'b0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
